// File: rtl/cnn_layer_accel_prefetch_row_loader.sv
// Write-side feeder for the prefetch row buffer: streams one row of pixels per fill,
// holds row_ready until the consumer asks for the next row, and sequences one job of rows.
module cnn_layer_accel_prefetch_row_loader #(
  parameter int unsigned C_PIXEL_WIDTH = 16,
  parameter int unsigned C_MAX_COLS    = 512,
  parameter int unsigned C_CNT_WIDTH   = 9
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic                     job_start,
  input  logic [C_CNT_WIDTH-1:0]   job_num_cols,
  input  logic [C_CNT_WIDTH-1:0]   job_num_rows,
  output logic                     job_busy,
  output logic                     job_done,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [C_PIXEL_WIDTH-1:0] pix_data,
  output logic [C_PIXEL_WIDTH-1:0] pbuf_din,
  output logic                     pbuf_wr_en,
  output logic                     pbuf_fetch_ack,
  output logic                     row_ready,
  input  logic                     row_req,
  output logic [C_CNT_WIDTH-1:0]   row_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_WAIT_REQ
  } state_t;

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

  state_t                   state, state_next;
  logic [C_CNT_WIDTH-1:0]   num_cols, num_cols_next;
  logic [C_CNT_WIDTH-1:0]   num_rows, num_rows_next;
  logic [C_CNT_WIDTH-1:0]   col_cnt, col_cnt_next;
  logic [C_CNT_WIDTH-1:0]   row_idx_next;
  logic [C_PIXEL_WIDTH-1:0] din_next;
  logic                     wr_en_next;
  logic                     ack_next;
  logic                     busy_next;
  logic                     done_next;
  logic                     row_ready_next;
  logic                     accept;
  logic [C_CNT_WIDTH-1:0]   wr_cnt;

  assign pix_ready = (state == ST_FILL);
  assign accept    = pix_valid && pix_ready;

  always_comb begin
    state_next     = state;
    num_cols_next  = num_cols;
    num_rows_next  = num_rows;
    col_cnt_next   = col_cnt;
    row_idx_next   = row_idx;
    din_next       = pbuf_din;
    wr_en_next     = 1'b0;
    ack_next       = 1'b0;
    busy_next      = job_busy;
    done_next      = 1'b0;
    row_ready_next = row_ready;

    case (state)
      ST_IDLE: begin
        if (job_start) begin
          if ((job_num_cols != '0) && (job_num_rows != '0)) begin
            num_cols_next = job_num_cols;
            num_rows_next = job_num_rows;
            col_cnt_next  = '0;
            row_idx_next  = '0;
            ack_next      = 1'b1;
            busy_next     = 1'b1;
            state_next    = ST_FILL;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      ST_FILL: begin
        if (accept) begin
          wr_en_next = 1'b1;
          din_next   = pix_data;
          if (col_cnt == num_cols - CNT_ONE) begin
            col_cnt_next = '0;
            state_next   = ST_DRAIN;
          end else begin
            col_cnt_next = col_cnt + CNT_ONE;
          end
        end
      end

      // The last write of the row is on the wire this cycle; announce the row after it.
      ST_DRAIN: begin
        row_ready_next = 1'b1;
        state_next     = ST_WAIT_REQ;
      end

      ST_WAIT_REQ: begin
        if (row_req) begin
          row_ready_next = 1'b0;
          if (row_idx == num_rows - CNT_ONE) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            row_idx_next = row_idx + CNT_ONE;
            ack_next     = 1'b1;
            state_next   = ST_FILL;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      num_cols       <= '0;
      num_rows       <= '0;
      col_cnt        <= '0;
      row_idx        <= '0;
      pbuf_din       <= '0;
      pbuf_wr_en     <= 1'b0;
      pbuf_fetch_ack <= 1'b0;
      job_busy       <= 1'b0;
      job_done       <= 1'b0;
      row_ready      <= 1'b0;
    end else begin
      state          <= state_next;
      num_cols       <= num_cols_next;
      num_rows       <= num_rows_next;
      col_cnt        <= col_cnt_next;
      row_idx        <= row_idx_next;
      pbuf_din       <= din_next;
      pbuf_wr_en     <= wr_en_next;
      pbuf_fetch_ack <= ack_next;
      job_busy       <= busy_next;
      job_done       <= done_next;
      row_ready      <= row_ready_next;
    end
  end

  // Writes issued since the last fetch ack; the DRAIN cycle carries the final one.
  always_ff @(posedge wr_clk) begin
    if (rst || pbuf_fetch_ack) begin
      wr_cnt <= '0;
    end else if (pbuf_wr_en) begin
      wr_cnt <= wr_cnt + CNT_ONE;
    end
  end

  a_wr_only_fill_drain: assert property (@(posedge wr_clk) disable iff (rst)
    pbuf_wr_en |-> ((state == ST_FILL) || (state == ST_DRAIN)));

  a_row_write_count: assert property (@(posedge wr_clk) disable iff (rst)
    (state == ST_DRAIN) |-> (wr_cnt == num_cols - CNT_ONE));

  a_ack_wr_exclusive: assert property (@(posedge wr_clk) disable iff (rst)
    !(pbuf_fetch_ack && pbuf_wr_en));

  a_cols_in_range: assert property (@(posedge wr_clk) disable iff (rst)
    ((state == ST_IDLE) && job_start) |-> (32'(job_num_cols) <= C_MAX_COLS));

endmodule

// File: tb/tb_cnn_layer_accel_prefetch_row_loader.sv
// Directed bench for the prefetch row loader: row fills, flow control, zero-size jobs,
// ignored row_req, mid-job reset and a full-width row.
module tb_cnn_layer_accel_prefetch_row_loader;

  localparam int unsigned PW = 16;
  // Ten count bits so a 512-pixel row can be requested on the size port.
  localparam int unsigned CW = 10;

  logic          wr_clk = 1'b0;
  logic          rst;
  logic          job_start;
  logic [CW-1:0] job_num_cols;
  logic [CW-1:0] job_num_rows;
  logic          job_busy;
  logic          job_done;
  logic          pix_valid;
  logic          pix_ready;
  logic [PW-1:0] pix_data;
  logic [PW-1:0] pbuf_din;
  logic          pbuf_wr_en;
  logic          pbuf_fetch_ack;
  logic          row_ready;
  logic          row_req;
  logic [CW-1:0] row_idx;

  cnn_layer_accel_prefetch_row_loader #(
    .C_PIXEL_WIDTH(PW),
    .C_MAX_COLS   (512),
    .C_CNT_WIDTH  (CW)
  ) dut (
    .wr_clk        (wr_clk),
    .rst           (rst),
    .job_start     (job_start),
    .job_num_cols  (job_num_cols),
    .job_num_rows  (job_num_rows),
    .job_busy      (job_busy),
    .job_done      (job_done),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pbuf_din      (pbuf_din),
    .pbuf_wr_en    (pbuf_wr_en),
    .pbuf_fetch_ack(pbuf_fetch_ack),
    .row_ready     (row_ready),
    .row_req       (row_req),
    .row_idx       (row_idx)
  );

  always #5 wr_clk = ~wr_clk;

  int n_tests = 0;
  int n_fail  = 0;

  int valid_mode;   // 0 idle, 1 constant, 2 toggling
  int req_delay;    // cycles after row_ready rise to pulse row_req; -1 never
  logic req_force;
  int next_pix;
  int cyc;
  int rr_rise_cyc;
  int last_req_cyc;
  int last_wr_cyc;
  int done_cyc;
  int ack_n, done_n, clash_n, busy_n, rr_n, wr_at_rr;
  logic rr_prev;
  int wr_q[$];
  int wr_cyc[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_cyc.delete();
    ack_n = 0; done_n = 0; clash_n = 0; busy_n = 0; rr_n = 0;
    wr_at_rr = -1; done_cyc = -1; last_req_cyc = -1000; last_wr_cyc = -1000;
    rr_rise_cyc = -1000;
    rr_prev = row_ready;
  endtask

  task automatic cycle();
    logic hs;
    case (valid_mode)
      0:       pix_valid = 1'b0;
      1:       pix_valid = 1'b1;
      default: pix_valid = !pix_valid;
    endcase
    pix_data = PW'(next_pix);
    row_req  = req_force ||
               ((req_delay >= 0) && row_ready && (cyc - rr_rise_cyc == req_delay));
    if (row_req) last_req_cyc = cyc;
    hs = pix_valid && pix_ready;
    @(posedge wr_clk);
    #1;
    cyc++;
    row_req = 1'b0;
    if (hs) next_pix++;
    if (pbuf_wr_en) begin
      wr_q.push_back(int'(pbuf_din));
      wr_cyc.push_back(cyc);
      last_wr_cyc = cyc;
    end
    if (pbuf_fetch_ack) ack_n++;
    if (pbuf_fetch_ack && pbuf_wr_en) clash_n++;
    if (job_busy) busy_n++;
    if (job_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (row_ready && !rr_prev) begin
      rr_rise_cyc = cyc;
      rr_n++;
      wr_at_rr = wr_q.size();
    end
    rr_prev = row_ready;
  endtask

  task automatic start_job(input int cols, input int rows);
    job_num_cols = CW'(cols);
    job_num_rows = CW'(rows);
    job_start = 1'b1;
    cycle();
    job_start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((done_n == 0) && (n < budget)) begin
      cycle();
      n++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"},  int'(job_busy), 0);
    check_eq({tag, "_done"},  int'(job_done), 0);
    check_eq({tag, "_din"},   int'(pbuf_din), 0);
    check_eq({tag, "_wr"},    int'(pbuf_wr_en), 0);
    check_eq({tag, "_ack"},   int'(pbuf_fetch_ack), 0);
    check_eq({tag, "_rdy"},   int'(row_ready), 0);
    check_eq({tag, "_ridx"},  int'(row_idx), 0);
    check_eq({tag, "_prdy"},  int'(pix_ready), 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; job_start = 1'b0; job_num_cols = '0; job_num_rows = '0;
    pix_valid = 1'b0; pix_data = '0; row_req = 1'b0; req_force = 1'b0;
    valid_mode = 0; req_delay = -1; next_pix = 0; cyc = 0;
    clear_logs();
    cycle(); cycle(); cycle();
    check_outputs_zero("reset");
    rst = 1'b0;
    cycle();

    // 1: two rows of four, row_req three cycles after each row_ready
    clear_logs();
    valid_mode = 1; req_delay = 3; next_pix = 1;
    start_job(4, 2);
    check_eq("t1_busy", int'(job_busy), 1);
    check_eq("t1_ack0", int'(pbuf_fetch_ack), 1);
    run_until_done(200);
    check_eq("t1_done_n", done_n, 1);
    check_eq("t1_acks", ack_n, 2);
    check_eq("t1_nwr", wr_q.size(), 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("t1_d%0d", i), (i < wr_q.size()) ? wr_q[i] : -1, i + 1);
    check_eq("t1_gap", (wr_cyc.size() == 8) ? wr_cyc[4] - wr_cyc[3] : -1, 6);
    check_eq("t1_done_lat", done_cyc - last_req_cyc, 1);
    check_eq("t1_rr_n", rr_n, 2);
    check_eq("t1_clash", clash_n, 0);
    cycle();
    check_eq("t1_busy_end", int'(job_busy), 0);

    // 2: one row of five with toggling valid
    clear_logs();
    valid_mode = 2; req_delay = 1; next_pix = 20;
    start_job(5, 1);
    run_until_done(200);
    check_eq("t2_nwr", wr_q.size(), 5);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] != 20 + i) bad++;
    check_eq("t2_order", bad, 0);
    check_eq("t2_rr_lat", rr_rise_cyc - last_wr_cyc, 1);
    check_eq("t2_wr_at_rr", wr_at_rr, 5);
    check_eq("t2_done_n", done_n, 1);

    // 3: zero-column job completes immediately without touching the buffer
    clear_logs();
    valid_mode = 1; req_delay = 1;
    start_job(0, 3);
    check_eq("t3_done", int'(job_done), 1);
    repeat (10) cycle();
    check_eq("t3_nwr", wr_q.size(), 0);
    check_eq("t3_acks", ack_n, 0);
    check_eq("t3_busy", busy_n, 0);
    check_eq("t3_done_n", done_n, 1);

    // 4: row_req during FILL is ignored; loader parks in WAIT_REQ
    clear_logs();
    valid_mode = 1; req_delay = -1; next_pix = 40;
    start_job(3, 2);
    req_force = 1'b1;
    cycle();
    req_force = 1'b0;
    repeat (30) cycle();
    check_eq("t4_nwr", wr_q.size(), 3);
    check_eq("t4_rdy", int'(row_ready), 1);
    check_eq("t4_prdy", int'(pix_ready), 0);
    check_eq("t4_ridx", int'(row_idx), 0);
    check_eq("t4_done_n", done_n, 0);
    check_eq("t4_acks", ack_n, 1);

    // 5: reset two pixels into the second row, then a clean job
    rst = 1'b1; valid_mode = 0; cycle(); rst = 1'b0; cycle();
    clear_logs();
    valid_mode = 1; req_delay = 2; next_pix = 100;
    start_job(4, 2);
    for (int n = 0; (n < 100) && (wr_q.size() < 6); n++) cycle();
    check_eq("t5_reach", wr_q.size(), 6);
    check_eq("t5_ridx1", int'(row_idx), 1);
    rst = 1'b1; valid_mode = 0;
    cycle();
    check_outputs_zero("t5_rst");
    rst = 1'b0;
    cycle();
    clear_logs();
    valid_mode = 1; req_delay = 1; next_pix = 200;
    start_job(3, 1);
    run_until_done(100);
    check_eq("t5_acks", ack_n, 1);
    check_eq("t5_nwr", wr_q.size(), 3);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] != 200 + i) bad++;
    check_eq("t5_order", bad, 0);
    check_eq("t5_done_n", done_n, 1);

    // 6: maximum-length row
    clear_logs();
    valid_mode = 1; req_delay = 1; next_pix = 1000;
    start_job(512, 1);
    run_until_done(700);
    check_eq("t6_nwr", wr_q.size(), 512);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] != 1000 + i) bad++;
    check_eq("t6_order", bad, 0);
    check_eq("t6_rr_n", rr_n, 1);
    check_eq("t6_wr_at_rr", wr_at_rr, 512);
    check_eq("t6_done_n", done_n, 1);
    check_eq("t6_clash", clash_n, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
